dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single synchronous data-memory port between two masters:
//  master 0 = CPU MEM stage (DM_addr/MemData/byteen), master 1 = DMA/debug
//  loader. Single-beat requests, req/gnt handshake, one-cycle-latency reads,
//  master-0 priority with a starvation counter guaranteeing master-1 progress.
// PARAMETERS
//  AW        32  address width (byte address; mem_addr is word-aligned [AW-1:2])
//  MAX_WAIT  4   consecutive m0 grants while m1 waits before m1 is forced
// PORTS
//  clk         in   1      clock
//  reset       in   1      synchronous, active-high
//  m_req       in   2      per-master request; held with command until gnt seen
//  m_we        in   2      per-master write(1)/read(0)
//  m_addr      in   2*AW   {m1,m0} byte addresses
//  m_wdata     in   64     {m1,m0} write data, already byte-lane aligned
//  m_byteen    in   8      {m1,m0} 4-bit byte enables (writes only)
//  m_gnt       out  2      one-hot, one-cycle pulse: command accepted
//  m_rvalid    out  2      one-hot, one-cycle pulse: m_rdata valid for master
//  m_rdata     out  32     read data (shared, qualified by m_rvalid)
//  m_stall     out  2      m_req[i] & ~m_gnt[i] (drives CPU freeze for i=0)
//  mem_addr    out  AW-2   word address to memory
//  mem_wdata   out  32     write data to memory
//  mem_byteen  out  4      byte write enables; 0 = read/no write
//  mem_rdata   in   32     memory read data, valid cycle after address
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, wait_cnt=0; all outputs 0.
//  - States: IDLE, ISSUE, RESP. Registered owner and latched command.
//  - IDLE: if any m_req, pick winner, latch addr/we/wdata/byteen -> ISSUE.
//    Pick: m1 if wait_cnt==MAX_WAIT and m_req[1]; else m0 if m_req[0];
//    else m1. No request: stay IDLE, mem_byteen=0.
//  - ISSUE (1 cycle): mem_* driven from latch; m_gnt[owner]=1.
//    Write: mem_byteen=latched byteen; next IDLE (no rvalid).
//    Read: mem_byteen=0; next RESP.
//  - RESP (1 cycle): m_rdata=mem_rdata, m_rvalid[owner]=1; next IDLE.
//  - Latency: write req->gnt 1 cycle after req sampled; read req->rvalid 2
//    cycles. Max one outstanding transaction; no back-to-back without IDLE.
//  - wait_cnt: on each m0 grant with m_req[1] high, increments (saturates at
//    MAX_WAIT); cleared on m1 grant or when m_req[1] low in IDLE.
//  - Withdrawal: req dropped before gnt cancels request (CPU flush on
//    exception); once in ISSUE/RESP the transaction completes regardless.
//  - m_byteen==0 on a write: still granted, memory not modified.
//  - Simultaneous req in IDLE: priority rule above; loser's m_stall stays 1.
//  - Reset mid-operation: abort immediately, no gnt/rvalid, mem_byteen=0 the
//    following cycle.
//  - Outputs outside their active state are 0 (mem_addr/mem_wdata hold
//    latched values, don't-care).
// TESTING
//  - m0 read 0x0000_0010 alone: mem_addr=0x4 in ISSUE, m_gnt=01, next cycle
//    m_rvalid=01, m_rdata=mem_rdata.
//  - m1 write 0x20, byteen 4'b0011, data 0xAABB_CCDD: mem_byteen=0011 for
//    exactly one cycle, m_gnt=10, no rvalid.
//  - Both masters request continuously, MAX_WAIT=4: grant pattern
//    m0,m0,m0,m0,m1, repeating; m_stall[1]=1 between grants.
//  - m0 drops req in IDLE before sampling: no gnt, no memory access.
//  - reset asserted during RESP: m_rvalid stays 0, state IDLE next cycle,
//    wait_cnt=0.
//  - m0 write with byteen=0: gnt pulses, mem_byteen=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous data-memory port between two single-beat masters.
//   Master 0 (CPU MEM stage) has priority; master 1 (DMA/debug loader) is
//   forced through after MAX_WAIT consecutive master-0 grants it sat through.
//   Each transaction runs IDLE -> ISSUE (-> RESP for reads) -> IDLE, so at
//   most one transaction is outstanding and there is always an IDLE cycle
//   between two transactions.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   m_req[1:0]        per-master request, held with its command until m_gnt
//   m_we[1:0]         per-master write(1)/read(0)
//   m_addr            {m1,m0} byte addresses, AW bits each
//   m_wdata           {m1,m0} 32-bit lane-aligned write data
//   m_byteen          {m1,m0} 4-bit byte enables (writes only)
//   m_gnt[1:0]        one-cycle pulse in ISSUE for the owning master
//   m_rvalid[1:0]     one-cycle pulse in RESP for the owning master
//   m_rdata           read data, valid with m_rvalid
//   m_stall[1:0]      m_req & ~m_gnt
//   mem_addr          word address (byte address [AW-1:2])
//   mem_wdata         write data to memory
//   mem_byteen        byte write enables, nonzero only in a write ISSUE
//   mem_rdata         memory read data, valid the cycle after the address
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      m_req,
  input  logic [1:0]      m_we,
  input  logic [2*AW-1:0] m_addr,
  input  logic [63:0]     m_wdata,
  input  logic [7:0]      m_byteen,
  output logic [1:0]      m_gnt,
  output logic [1:0]      m_rvalid,
  output logic [31:0]     m_rdata,
  output logic [1:0]      m_stall,
  output logic [AW-3:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_byteen,
  input  logic [31:0]     mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_ONE = {{(WW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          lat_we, lat_we_nxt;
  logic [AW-3:0] lat_addr, lat_addr_nxt;
  logic [31:0]   lat_wdata, lat_wdata_nxt;
  logic [3:0]    lat_byteen, lat_byteen_nxt;
  logic          pick_m1;

  // Byte-offset bits are meaningless for a word-wide memory.
  logic [3:0]    unused_addr_lsb;
  assign unused_addr_lsb = {m_addr[AW+1:AW], m_addr[1:0]};

  // Master 1 wins when it has been starved long enough or master 0 is silent.
  assign pick_m1 = m_req[1] & ((wait_cnt == WAIT_MAX) | ~m_req[0]);

  // State, owner, starvation counter and latched command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0000_0000;
      lat_byteen <= 4'b0000;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      wait_cnt   <= wait_nxt;
      lat_we     <= lat_we_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
      lat_byteen <= lat_byteen_nxt;
    end
  end

  // Next-state: arbitration, command capture and starvation bookkeeping.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    wait_nxt       = wait_cnt;
    lat_we_nxt     = lat_we;
    lat_addr_nxt   = lat_addr;
    lat_wdata_nxt  = lat_wdata;
    lat_byteen_nxt = lat_byteen;
    case (state)
      IDLE: begin
        if (m_req != 2'b00) begin
          state_nxt = ISSUE;
          owner_nxt = pick_m1;
          if (pick_m1) begin
            lat_we_nxt     = m_we[1];
            lat_addr_nxt   = m_addr[2*AW-1:AW+2];
            lat_wdata_nxt  = m_wdata[63:32];
            lat_byteen_nxt = m_byteen[7:4];
            wait_nxt       = '0;
          end else begin
            lat_we_nxt     = m_we[0];
            lat_addr_nxt   = m_addr[AW-1:2];
            lat_wdata_nxt  = m_wdata[31:0];
            lat_byteen_nxt = m_byteen[3:0];
            // Count only the m0 grants that master 1 actually waited through.
            if (m_req[1]) begin
              wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_ONE;
            end else begin
              wait_nxt = '0;
            end
          end
        end else begin
          wait_nxt = '0;
        end
      end
      ISSUE: begin
        state_nxt = lat_we ? IDLE : RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode; reset suppresses handshakes and writes in the same cycle.
  always_comb begin
    m_gnt      = 2'b00;
    m_rvalid   = 2'b00;
    m_rdata    = 32'h0000_0000;
    mem_byteen = 4'b0000;
    case (state)
      ISSUE: begin
        if (!reset) begin
          m_gnt[owner] = 1'b1;
          mem_byteen   = lat_we ? lat_byteen : 4'b0000;
        end else begin
          m_gnt      = 2'b00;
          mem_byteen = 4'b0000;
        end
      end
      RESP: begin
        if (!reset) begin
          m_rvalid[owner] = 1'b1;
          m_rdata         = mem_rdata;
        end else begin
          m_rvalid = 2'b00;
          m_rdata  = 32'h0000_0000;
        end
      end
      default: begin
        m_gnt = 2'b00;
      end
    endcase
  end

  assign m_stall   = m_req & ~m_gnt;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed stimulus, a transaction-level
// reference model checked every cycle, and hand-computed pinned values.
module tb_dmem_arbiter;
  localparam int AW       = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    m_req, m_we;
  logic [63:0]   m_addr;
  logic [63:0]   m_wdata;
  logic [7:0]    m_byteen;
  logic [1:0]    m_gnt, m_rvalid, m_stall;
  logic [31:0]   m_rdata;
  logic [29:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byteen;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byteen(m_byteen), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_stall(m_stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: reinitialised while reset is high.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + i;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  // Reference model: a transaction accepted at a sampled edge shows its
  // grant one cycle later and, for reads, its data the cycle after that.
  logic [31:0] ref_mem [256];
  bit          busy;
  int          age, own, wcnt;
  logic        t_we;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_be;

  initial begin
    logic [1:0]  eg, ev;
    logic [3:0]  eb;
    logic [31:0] ed;
    busy = 1'b0; wcnt = 0; age = 0; own = 0;
    forever begin
      @(negedge clk);
      eg = 2'b00; ev = 2'b00; eb = 4'b0000; ed = 32'h0;
      if (!reset && busy) begin
        if (age == 1) begin
          eg[own] = 1'b1;
          eb = t_we ? t_be : 4'b0000;
          chk("mem_addr", {2'b00, mem_addr}, t_addr >> 2);
          if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end else begin
          ev[own] = 1'b1;
          ed = t_rdata;
        end
      end
      chk("m_gnt", m_gnt, eg);
      chk("m_rvalid", m_rvalid, ev);
      chk("m_rdata", m_rdata, ed);
      chk("mem_byteen", mem_byteen, eb);
      chk("m_stall", m_stall, m_req & ~eg);
      // advance to what the coming edge does
      if (reset) begin
        busy = 1'b0; wcnt = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + i;
      end else if (busy) begin
        if (age == 1 && !t_we) age = 2;
        else busy = 1'b0;
      end else if (m_req != 2'b00) begin
        if (wcnt == MAX_WAIT && m_req[1]) own = 1;
        else if (m_req[0]) own = 0;
        else own = 1;
        if (own == 1) wcnt = 0;
        else if (m_req[1]) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
        else wcnt = 0;
        t_we = m_we[own]; t_addr = m_addr[own*32 +: 32];
        t_wdata = m_wdata[own*32 +: 32]; t_be = m_byteen[own*4 +: 4];
        if (t_we) begin
          for (int b = 0; b < 4; b++)
            if (t_be[b]) ref_mem[t_addr[9:2]][b*8 +: 8] = t_wdata[b*8 +: 8];
        end else begin
          t_rdata = ref_mem[t_addr[9:2]];
        end
        busy = 1'b1; age = 1;
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic drive_point();
    @(posedge clk); #2;
  endtask

  task automatic txn(input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
    bit got;
    got = 1'b0;
    m_req[m] = 1'b1; m_we[m] = we; m_addr[m*32 +: 32] = addr;
    m_wdata[m*32 +: 32] = data; m_byteen[m*4 +: 4] = be;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (m_gnt[m]) got = 1'b1;
    end
    chk("txn_gnt_seen", {31'b0, got}, 32'h1);
    drive_point();
    m_req[m] = 1'b0;
    if (!we) drive_point();
  endtask

  task automatic collect(input int want, output int n, output logic [9:0] glog);
    n = 0; glog = 10'b0;
    for (int k = 0; k < 80 && n < want; k++) begin
      @(negedge clk);
      if (m_gnt != 2'b00) begin
        glog = {glog[8:0], m_gnt[1]};
        n++;
      end
    end
  endtask

  initial begin
    int n;
    logic [9:0] glog;
    bit got;
    reset = 1'b1; m_req = 2'b00; m_we = 2'b00; m_addr = 64'h0;
    m_wdata = 64'h0; m_byteen = 8'h00;
    repeat (3) drive_point();
    @(negedge clk);
    chk("rst_gnt", m_gnt, 32'h0);
    chk("rst_rvalid", m_rvalid, 32'h0);
    chk("rst_byteen", mem_byteen, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    drive_point();
    reset = 1'b0;
    repeat (2) drive_point();

    // m0 read of 0x10
    m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[31:0] = 32'h0000_0010;
    @(negedge clk);
    chk("t_rd_stall_idle", m_stall, 32'h1);
    drive_point();
    @(negedge clk);
    chk("t_rd_gnt", m_gnt, 32'h1);
    chk("t_rd_addr", mem_addr, 32'h4);
    drive_point();
    m_req[0] = 1'b0;
    @(negedge clk);
    chk("t_rd_rvalid", m_rvalid, 32'h1);
    chk("t_rd_rdata", m_rdata, 32'hC0DE_0004);
    drive_point();

    // m1 partial write to 0x20
    m_req[1] = 1'b1; m_we[1] = 1'b1; m_addr[63:32] = 32'h0000_0020;
    m_wdata[63:32] = 32'hAABB_CCDD; m_byteen[7:4] = 4'b0011;
    drive_point();
    @(negedge clk);
    chk("t_wr_gnt", m_gnt, 32'h2);
    chk("t_wr_byteen", mem_byteen, 32'h3);
    drive_point();
    m_req[1] = 1'b0;
    @(negedge clk);
    chk("t_wr_byteen_after", mem_byteen, 32'h0);
    chk("t_wr_no_rvalid", m_rvalid, 32'h0);
    chk("t_wr_mem", mem[8], 32'hC0DE_CCDD);
    drive_point();
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    txn(1, 1'b0, 32'h0000_0024, 32'h0, 4'h0);

    // m0 write with no byte enables
    txn(0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000);
    @(negedge clk);
    chk("t_be0_mem", mem[12], 32'hC0DE_000C);
    drive_point();

    // request withdrawn before it is sampled
    m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[31:0] = 32'h0000_0040;
    m_wdata[31:0] = 32'h1234_5678; m_byteen[3:0] = 4'hF;
    #2;
    m_req[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t_wd_gnt", m_gnt, 32'h0);
      chk("t_wd_byteen", mem_byteen, 32'h0);
    end
    chk("t_wd_mem", mem[16], 32'hC0DE_0010);
    drive_point();
    drive_point();

    // both masters requesting continuously
    m_we = 2'b00; m_addr = {32'h0000_0104, 32'h0000_0100}; m_req = 2'b11;
    collect(10, n, glog);
    chk("t_cont_count", n, 32'd10);
    chk("t_cont_pattern", {22'b0, glog}, 32'b0000100001);
    drive_point();
    m_req = 2'b00;
    repeat (4) drive_point();

    // reset during RESP, with master 1 already waiting
    m_req = 2'b11;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (m_gnt != 2'b00) got = 1'b1;
    end
    chk("t_rst_first_gnt", {31'b0, got}, 32'h1);
    drive_point();
    reset = 1'b1;
    @(negedge clk);
    chk("t_rst_rvalid", m_rvalid, 32'h0);
    drive_point();
    reset = 1'b0;
    @(negedge clk);
    chk("t_rst_after_gnt", m_gnt, 32'h0);
    chk("t_rst_after_stall", m_stall, 32'h3);
    collect(5, n, glog);
    chk("t_rst_pattern", {22'b0, glog}, 32'b00001);
    drive_point();
    m_req = 2'b00;
    repeat (4) drive_point();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal;
  end
endmodule
